// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL/soft-reset sources and the reset sequencer.
// No valid/ready handshake: every signal is a level, sampled on each clk edge by its receiver.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       sdram_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] lock_loss_count;
  logic [2:0] seq_state;

  modport master (
    output pll_locked,
    output soft_reset_req,
    input  sdram_rst,
    input  sys_rst,
    input  ready,
    input  lock_loss_count,
    input  seq_state
  );

  modport slave (
    input  pll_locked,
    input  soft_reset_req,
    output sdram_rst,
    output sys_rst,
    output ready,
    output lock_loss_count,
    output seq_state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, then releases SDRAM reset and system reset in a timed order;
// any loss of lock re-asserts both resets and is counted.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int SDRAM_DELAY_CYCLES = 10000,
  parameter int SYS_DELAY_CYCLES   = 16,
  parameter int SOFT_CYCLES        = 16,
  parameter int CNT_W              = 16
) (
  input logic                  clk,
  input logic                  rst,
  pll_reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    SDRAM_WAIT = 3'd1,
    SYS_WAIT   = 3'd2,
    RUN        = 3'd3,
    SOFT       = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SDRAM_LAST = CNT_W'(SDRAM_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST   = CNT_W'(SYS_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [7:0]             llc_q;
  logic                   sdram_rst_d;
  logic                   sys_rst_d;
  logic                   ready_d;

  // The only place pll_locked is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      llc_q   <= '0;
    end else if (state_q != WAIT_LOCK && !lock_s &&
                 (state_q == SDRAM_WAIT || state_q == SYS_WAIT ||
                  state_q == RUN || state_q == SOFT)) begin
      // Lock loss outranks soft requests and counter expiry.
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      if (llc_q != 8'hFF) llc_q <= llc_q + 8'd1;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt_q <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q <= SDRAM_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SDRAM_WAIT: begin
          if (cnt_q == SDRAM_LAST) begin
            state_q <= SYS_WAIT;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        SYS_WAIT: begin
          if (cnt_q == SYS_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          cnt_q <= '0;
          if (bus.soft_reset_req) state_q <= SOFT;
        end
        SOFT: begin
          if (cnt_q == SOFT_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          // Illegal encodings recover silently, not counted as lock loss.
          state_q <= WAIT_LOCK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    sdram_rst_d = 1'b1;
    sys_rst_d   = 1'b1;
    ready_d     = 1'b0;
    case (state_q)
      SDRAM_WAIT: begin sdram_rst_d = 1'b0; sys_rst_d = 1'b1; end
      SYS_WAIT:   begin sdram_rst_d = 1'b0; sys_rst_d = 1'b0; end
      RUN:        begin sdram_rst_d = 1'b0; sys_rst_d = 1'b0; ready_d = 1'b1; end
      SOFT:       begin sdram_rst_d = 1'b0; sys_rst_d = 1'b1; end
      default:    begin sdram_rst_d = 1'b1; sys_rst_d = 1'b1; end
    endcase
  end

  assign bus.sdram_rst       = sdram_rst_d;
  assign bus.sys_rst         = sys_rst_d;
  assign bus.ready           = ready_d;
  assign bus.lock_loss_count = llc_q;
  assign bus.seq_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expected output vectors are queued per edge
// from the sequence timing, then popped and compared 1 time unit after each edge.
module tb_pll_reset_sequencer;

  logic clk;
  logic rst;
  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(8),
    .SDRAM_DELAY_CYCLES(20),
    .SYS_DELAY_CYCLES  (4),
    .SOFT_CYCLES       (6),
    .CNT_W             (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {sdram_rst, sys_rst, ready, lock_loss_count[7:0], seq_state[2:0]}
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_llc = 8'd0;

  function automatic logic [13:0] vec(logic sd, logic sy, logic rd, logic [7:0] c, logic [2:0] st);
    return {sd, sy, rd, c, st};
  endfunction

  function automatic logic [13:0] v_wait(logic [7:0] c);  return vec(1'b1, 1'b1, 1'b0, c, 3'd0); endfunction
  function automatic logic [13:0] v_sdram(logic [7:0] c); return vec(1'b0, 1'b1, 1'b0, c, 3'd1); endfunction
  function automatic logic [13:0] v_sys(logic [7:0] c);   return vec(1'b0, 1'b0, 1'b0, c, 3'd2); endfunction
  function automatic logic [13:0] v_run(logic [7:0] c);   return vec(1'b0, 1'b0, 1'b1, c, 3'd3); endfunction
  function automatic logic [13:0] v_soft(logic [7:0] c);  return vec(1'b0, 1'b1, 1'b0, c, 3'd4); endfunction

  task automatic push(input int n, input logic [13:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  task automatic check_now(input string tag);
    logic [13:0] obs;
    logic [13:0] exp;
    obs = {bus.sdram_rst, bus.sys_rst, bus.ready, bus.lock_loss_count, bus.seq_state};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h but expected queue is empty", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic step_chk(input string tag);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step_chk(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after "edge 0" with lock_s low: raise pll_locked and expect
  // sdram_rst release at edge 10, sys_rst at edge 30, ready at edge 34.
  // soft_at > 0 pulses soft_reset_req for one cycle after that edge.
  task automatic do_lock(input int soft_at, input string tag);
    bus.pll_locked = 1'b1;
    push(9,  v_wait(exp_llc));
    push(20, v_sdram(exp_llc));
    push(4,  v_sys(exp_llc));
    push(1,  v_run(exp_llc));
    for (int i = 1; i <= 34; i++) begin
      step_chk(tag);
      bus.soft_reset_req = (i == soft_at);
    end
    bus.soft_reset_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.pll_locked = 1'b0;
    bus.soft_reset_req = 1'b0;

    // Power-up: reset held, then 50 unlocked cycles in WAIT_LOCK.
    push(5, v_wait(8'd0));
    steps(5, "reset_hold");
    rst = 1'b0;
    push(50, v_wait(8'd0));
    steps(50, "unlocked_idle");

    // Clean lock and RUN hold.
    do_lock(0, "clean_lock");
    push(3, v_run(exp_llc));
    steps(3, "run_hold");

    // Soft reset: one-cycle pulse gives exactly 6 cycles of sys_rst.
    bus.soft_reset_req = 1'b1;
    push(6, v_soft(exp_llc));
    push(3, v_run(exp_llc));
    step_chk("soft_enter");
    bus.soft_reset_req = 1'b0;
    steps(8, "soft_pulse");

    // Loss in RUN: 3-edge latency, counted once.
    bus.pll_locked = 1'b0;
    push(2, v_run(exp_llc));
    exp_llc = exp_llc + 8'd1;
    push(5, v_wait(exp_llc));
    steps(7, "loss_in_run");

    // Re-lock with a soft request during SDRAM_WAIT (must be ignored).
    do_lock(15, "relock_soft_ignored");

    // Drop lock again, then a 1-cycle glitch during qualification.
    bus.pll_locked = 1'b0;
    push(2, v_run(exp_llc));
    exp_llc = exp_llc + 8'd1;
    push(4, v_wait(exp_llc));
    steps(6, "loss_before_glitch");
    bus.pll_locked = 1'b1;
    push(5, v_wait(exp_llc));
    steps(5, "glitch_high");
    bus.pll_locked = 1'b0;
    push(1, v_wait(exp_llc));
    steps(1, "glitch_low");
    do_lock(0, "glitch_requalify");

    // Priority: lock_s falls on the same edge soft_reset_req is sampled.
    bus.pll_locked = 1'b0;
    push(2, v_run(exp_llc));
    steps(2, "prio_run");
    bus.soft_reset_req = 1'b1;
    exp_llc = exp_llc + 8'd1;
    push(1, v_wait(exp_llc));
    step_chk("prio_loss_wins");
    bus.soft_reset_req = 1'b0;
    push(3, v_wait(exp_llc));
    steps(3, "prio_after");

    // Saturation: force losses from SDRAM_WAIT until well past 255.
    for (int n = 0; n < 260; n++) begin
      bus.pll_locked = 1'b1;
      idle(10);
      bus.pll_locked = 1'b0;
      idle(2);
      if (exp_llc != 8'hFF) exp_llc = exp_llc + 8'd1;
      push(1, v_wait(exp_llc));
      step_chk("sat_loss");
    end

    // Asynchronous reset from RUN clears the count immediately.
    do_lock(0, "lock_before_rst");
    rst = 1'b1;
    #1;
    exp_llc = 8'd0;
    push(1, v_wait(8'd0));
    check_now("async_rst");
    bus.pll_locked = 1'b0;
    idle(2);
    rst = 1'b0;
    push(3, v_wait(8'd0));
    steps(3, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the system/SDRAM PLL and consumes its asynchronous `locked` output.
- Synchronises and qualifies the lock, then releases the SDRAM controller reset and the system reset in a fixed, timed order.
- Re-asserts both resets on any loss of lock.
- Counts lock-loss events and offers a software-triggered system-only reset.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in the `pll_locked` synchroniser; legal range 2..4.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-locked cycles required before the SDRAM reset is released.
- SDRAM_DELAY_CYCLES, 10000: cycles `sdram_rst` stays low before `sys_rst` is released (100 us at 100 MHz).
- SYS_DELAY_CYCLES, 16: cycles `sys_rst` stays low before `ready` asserts.
- SOFT_CYCLES, 16: length of the `sys_rst` pulse for a soft reset.
- CNT_W, 16: width of the internal delay counter; must hold the largest *_CYCLES - 1.

Ports:
- clk, in, 1: PLL output clock (outclk_0 domain); the only clock.
- rst, in, 1: asynchronous active-high reset.
- pll_locked, in, 1: PLL `locked`, asynchronous to `clk`.
- soft_reset_req, in, 1: synchronous level/pulse request for a system-only reset.
- sdram_rst, out, 1: active-high reset to the SDRAM controller.
- sys_rst, out, 1: active-high reset to the rest of the system.
- ready, out, 1: high when the sequence is complete and the lock is held.
- lock_loss_count, out, 8: saturating count of lock-loss events.
- seq_state, out, 3: current state encoding, for debug.

Behaviour:
- Reset (rst=1, asynchronous):
  - State, counter and synchroniser chain clear to 0; state = WAIT_LOCK.
  - Outputs: sdram_rst=1, sys_rst=1, ready=0, lock_loss_count=0, seq_state=0.
- Synchroniser: `lock_s` is `pll_locked` after SYNC_STAGES flops clocked by `clk`. No other logic samples `pll_locked`.
- Outputs are Moore-decoded from the registered state, with no extra output register.
- Delay counter:
  - Clears to 0 on every state entry and increments once per cycle in the state.
  - "State lasts N cycles" means the transition happens on the edge where the counter equals N-1.
- States (encoding / outputs sdram_rst, sys_rst, ready):
  - WAIT_LOCK (0 / 1,1,0):
    - Counter increments only while lock_s=1.
    - lock_s=0 clears the counter and the state is held.
    - Go to SDRAM_WAIT on the edge where the counter = LOCK_STABLE_CYCLES-1 and lock_s=1.
  - SDRAM_WAIT (1 / 0,1,0): lasts SDRAM_DELAY_CYCLES, then go to SYS_WAIT.
  - SYS_WAIT (2 / 0,0,0): lasts SYS_DELAY_CYCLES, then go to RUN.
  - RUN (3 / 0,0,1):
    - Held indefinitely.
    - soft_reset_req=1 goes to SOFT.
  - SOFT (4 / 0,1,0): lasts SOFT_CYCLES, then returns to RUN. `sdram_rst` is not touched.
- Lock loss:
  - In any state other than WAIT_LOCK, lock_s=0 at an edge forces WAIT_LOCK on that edge.
  - Lock loss has priority over every other transition, including soft_reset_req and counter expiry in the same cycle.
  - lock_loss_count increments by 1 on each such transition and saturates at 255.
  - Latency: `pll_locked` falling to `sdram_rst`/`sys_rst`=1 and `ready`=0 is SYNC_STAGES+1 clk edges.
- Glitch filtering: a lock_s=0 glitch during WAIT_LOCK restarts the full LOCK_STABLE_CYCLES qualification and is not counted.
- soft_reset_req is ignored in every state except RUN. Holding it high re-enters SOFT after every return to RUN.
- Invariant: sdram_rst=1 implies sys_rst=1. ready=1 only in RUN.
- Encodings 5..7 are illegal; from an illegal encoding go to WAIT_LOCK on the next edge, without counting a lock loss.
- rst asserted mid-sequence returns immediately (asynchronously) to the reset values, including clearing lock_loss_count.

Test Plan:
All tests use SYNC=2, LOCK_STABLE=8, SDRAM_DELAY=20, SYS_DELAY=4, SOFT=6.
- Power-up: rst high 5 cycles, then release, with pll_locked held 0 for 50 cycles → sdram_rst=1, sys_rst=1, ready=0 and seq_state=0 throughout; lock_loss_count=0.
- Clean lock: pll_locked rises synchronously at edge 0 and stays high → sdram_rst falls at edge 10, sys_rst falls at edge 30, ready rises at edge 34, seq_state ends at 3.
- Qualification glitch: pll_locked high for 5 cycles, low for 1 cycle, then high → sdram_rst release is delayed to 10 edges after the second rise; lock_loss_count stays 0.
- Loss in RUN: from RUN, drop pll_locked → 3 edges later sdram_rst=1, sys_rst=1, ready=0 and lock_loss_count=1. Re-lock repeats the 10/30/34 timing.
- Soft reset: 1-cycle soft_reset_req pulse in RUN → sys_rst=1 and ready=0 for exactly 6 cycles, sdram_rst stays 0, then ready=1. A request during SDRAM_WAIT has no effect.
- Priority and saturation: drop pll_locked in the same cycle soft_reset_req is asserted → state goes to WAIT_LOCK, not SOFT. After 260 forced losses, lock_loss_count=255. A mid-RUN rst pulse clears the count to 0.
